// File: rtl/kmp_text_matcher_pkg.sv
// Shared parameters and FSM state encoding for the KMP text matcher.
// Contents: character width, pattern size, index widths, one-hot scan states.
// Imported by kmp_text_matcher and kmp_byte_skid.
package SME_spec_param;

    localparam int BYTE        = 8;  // bits per character
    localparam int MAX_PATTERN = 8;  // maximum pattern length
    localparam int MAX_PAT_ADD = 3;  // pattern index / failure entry width
    localparam int STR_ADD     = 6;  // text index, match position, match counter width

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_SCAN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

endpackage

// File: rtl/kmp_byte_skid.sv
// One-entry holding register for the text stream, with accept/consume logic.
// Ports: scan_i enables acceptance; exp_byte_i/j_zero_i decide whether the held byte
//        is consumed this cycle; t_* is the upstream handshake; cur_* is the held byte.
// t_ready_o depends only on registered state, never on t_valid_i or t_data_i.
module kmp_byte_skid
    import SME_spec_param::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_i,
    input  logic [BYTE-1:0] exp_byte_i,
    input  logic            j_zero_i,
    input  logic            t_valid_i,
    input  logic [BYTE-1:0] t_data_i,
    input  logic            t_last_i,
    output logic            t_ready_o,
    output logic            consume_o,
    output logic [BYTE-1:0] cur_byte_o,
    output logic            cur_last_o
);

    logic [BYTE-1:0] cur_byte_q;
    logic            cur_last_q;
    logic            cur_full_q;

    // A byte leaves the register when it matches the expected pattern character,
    // or when the matcher is at j==0 (a mismatch there simply skips the byte).
    assign consume_o  = scan_i && cur_full_q && ((cur_byte_q == exp_byte_i) || j_zero_i);
    assign t_ready_o  = scan_i && (!cur_full_q || consume_o);
    assign cur_byte_o = cur_byte_q;
    assign cur_last_o = cur_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_byte_q <= '0;
            cur_last_q <= 1'b0;
            cur_full_q <= 1'b0;
        end else if (!scan_i) begin
            // Leaving the scan (abort or job end) discards whatever is held.
            cur_full_q <= 1'b0;
        end else if (t_valid_i && t_ready_o) begin
            cur_byte_q <= t_data_i;
            cur_last_q <= t_last_i;
            cur_full_q <= 1'b1;
        end else if (consume_o) begin
            cur_full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/kmp_text_matcher.sv
// KMP text scanner: latches pattern and failure table, streams text, reports every match start.
// Ports: ff_valid/pattern/last_pat_idx/fail_func job setup (level); t_valid/t_data/t_last/t_ready
//        text stream; match_valid/match_pos/match_count match reports; done scan-complete level.
// A mismatch with j>0 stalls the held byte one cycle per failure-table step.
module kmp_text_matcher
    import SME_spec_param::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ff_valid,
    input  logic [MAX_PATTERN*BYTE-1:0]    pattern,
    input  logic [MAX_PAT_ADD-1:0]         last_pat_idx,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
    input  logic                           t_valid,
    input  logic [BYTE-1:0]                t_data,
    input  logic                           t_last,
    output logic                           t_ready,
    output logic                           match_valid,
    output logic [STR_ADD-1:0]             match_pos,
    output logic [STR_ADD-1:0]             match_count,
    output logic                           done
);

    state_t                                    state_q;
    logic [MAX_PATTERN-1:0][BYTE-1:0]          pat_q;
    logic [MAX_PATTERN-1:0][MAX_PAT_ADD-1:0]   ff_q;
    logic [MAX_PAT_ADD-1:0]                    last_q;
    logic [MAX_PAT_ADD-1:0]                    j_q;
    logic [STR_ADD-1:0]                        text_idx_q;
    logic                                      match_valid_q;
    logic [STR_ADD-1:0]                        match_pos_q;
    logic [STR_ADD-1:0]                        match_count_q;
    logic                                      done_q;

    logic            scan;
    logic            consume;
    logic [BYTE-1:0] cur_byte;
    logic            cur_last;
    logic            eq;

    assign scan = (state_q == ST_SCAN);
    assign eq   = (cur_byte == pat_q[j_q]);

    kmp_byte_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .scan_i     (scan),
        .exp_byte_i (pat_q[j_q]),
        .j_zero_i   (j_q == '0),
        .t_valid_i  (t_valid),
        .t_data_i   (t_data),
        .t_last_i   (t_last),
        .t_ready_o  (t_ready),
        .consume_o  (consume),
        .cur_byte_o (cur_byte),
        .cur_last_o (cur_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pat_q         <= '0;
            ff_q          <= '0;
            last_q        <= '0;
            j_q           <= '0;
            text_idx_q    <= '0;
            match_valid_q <= 1'b0;
            match_pos_q   <= '0;
            match_count_q <= '0;
            done_q        <= 1'b0;
        end else begin
            match_valid_q <= 1'b0;
            if (!ff_valid && state_q != ST_IDLE) begin
                // Job withdrawn: abandon it, keep the last reported values.
                state_q <= ST_IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ff_valid) state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        pat_q         <= pattern;
                        ff_q          <= fail_func;
                        last_q        <= last_pat_idx;
                        j_q           <= '0;
                        text_idx_q    <= '0;
                        match_count_q <= '0;
                        done_q        <= 1'b0;
                        state_q       <= ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (eq && consume) begin
                            if (j_q == last_q) begin
                                match_valid_q <= 1'b1;
                                match_pos_q   <= text_idx_q
                                               - {{(STR_ADD-MAX_PAT_ADD){1'b0}}, last_q};
                                if (match_count_q != '1) match_count_q <= match_count_q + 1'b1;
                                j_q <= ff_q[last_q];
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                        end else if (!consume && j_q != '0 && cur_full_mismatch()) begin
                            // Fall back in the failure table; the byte stays held.
                            j_q <= ff_q[j_q - 1'b1];
                        end
                        if (consume) begin
                            text_idx_q <= text_idx_q + 1'b1;
                            if (cur_last) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // A held byte that mismatches at j>0 is exactly a held byte that was not consumed.
    function automatic logic cur_full_mismatch();
        return t_ready == 1'b0;
    endfunction

    assign match_valid = match_valid_q;
    assign match_pos   = match_pos_q;
    assign match_count = match_count_q;
    assign done        = done_q;

endmodule
